// File: rtl/uart_transmitter.sv
// UART transmitter: sends one 10-bit frame per start request.
// A frame is a start bit (0), eight data bits LSB first, and a stop bit (1).
// The line output is registered, so it trails the FSM state by one clock.

// Bit-position counter.
// Counts completed bits, saturates at 10 and has a synchronous clear.
module uart_tx_counter (
   input  logic       i_clk,
   input  logic       i_clr,
   input  logic       i_en,
   output logic [3:0] o_count
);
   logic [3:0] count;
   logic [3:0] count_d;

   // Next count: clear wins; otherwise step once per bit and stop at 10.
   always_comb begin
      count_d = count;
      if (i_clr)
         count_d = 4'd0;
      else if (i_en && count != 4'd10)
         count_d = count + 4'd1;
   end

   // Count register.
   always_ff @(posedge i_clk) begin
      count <= count_d;
   end

   assign o_count = count;
endmodule

module uart_transmitter #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_Txstart,
   input  logic [7:0] i_datain,
   output logic       o_Txdataout
);
   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [7:0]         shreg_q, shreg_d;
   logic               line_q, line_d;
   logic [3:0]         cnt;
   logic               cnt_en, cnt_clr;
   logic               bit_done;

   assign bit_done = (div_q == DIV_W'(CLKS_PER_BIT - 1));

   // Next-state logic: the divider paces each bit; the counter tracks the
   // bit position so DATA knows when the eighth bit has gone out.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      shreg_d = shreg_q;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (i_Txstart) begin
               shreg_d = i_datain;
               state_d = START;
            end
         end
         START, DATA, STOP: begin
            if (bit_done) begin
               div_d  = '0;
               cnt_en = 1'b1;
               case (state_q)
                  START: state_d = DATA;
                  DATA: begin
                     shreg_d = shreg_q >> 1;
                     if (cnt == 4'd8) state_d = STOP;
                  end
                  default: state_d = DONE;
               endcase
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DONE: begin
            // Requiring the request to drop makes a held level send one frame.
            if (!i_Txstart) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line value for the current state; it is registered on the next edge.
   always_comb begin
      case (state_q)
         START:   line_d = 1'b0;
         DATA:    line_d = shreg_q[0];
         default: line_d = 1'b1;
      endcase
   end

   // FSM, divider, shift register and registered line output.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         shreg_q <= 8'd0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         shreg_q <= shreg_d;
         line_q  <= line_d;
      end
   end

   uart_tx_counter COUNTER_t (
      .i_clk   (i_clk),
      .i_clr   (i_reset | cnt_clr),
      .i_en    (cnt_en),
      .o_count (cnt)
   );

   assign o_Txdataout = line_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter. Two instances share the same stimulus:
// one with one clock per bit and one with four clocks per bit.
// The reference model computes the expected line level and bit count for
// each cycle after the request directly from the frame layout.
module tb_uart_transmitter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] din = 8'd0;
   logic       tx1, tx4;
   int         errs = 0;
   int         checks = 0;

   uart_transmitter #(.CLKS_PER_BIT(1)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_Txstart(start), .i_datain(din), .o_Txdataout(tx1));
   uart_transmitter #(.CLKS_PER_BIT(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_Txstart(start), .i_datain(din), .o_Txdataout(tx4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame bit i: 0 is the start bit, 1..8 are data LSB first, 9 is the stop bit.
   function automatic logic [31:0] fbit(input logic [7:0] d, input int i);
      if (i == 0) return 32'd0;
      if (i == 9) return 32'd1;
      return {31'd0, d[i-1]};
   endfunction

   function automatic logic [31:0] min10(input int v);
      return (v > 10) ? 32'd10 : v;
   endfunction

   task automatic idle_check(input int n);
      repeat (n) begin
         @(posedge clk); @(negedge clk);
         chk("idle_tx1", {31'd0, tx1}, 32'd1);
         chk("idle_cnt1", {28'd0, dut1.COUNTER_t.count}, 32'd0);
         chk("idle_tx4", {31'd0, tx4}, 32'd1);
         chk("idle_cnt4", {28'd0, dut4.COUNTER_t.count}, 32'd0);
      end
   endtask

   // Send byte d with the request held high through DONE. Optionally change
   // the data input at cycle chg, or assert reset at cycle rst_at.
   // Cycle j counts edges after the edge that sampled the request.
   task automatic run_frame(input logic [7:0] d, input int chg, input logic [7:0] d2,
                            input int rst_at);
      @(negedge clk);
      din = d;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("sample_tx1", {31'd0, tx1}, 32'd1);
      chk("sample_tx4", {31'd0, tx4}, 32'd1);
      for (int j = 1; j <= 44; j++) begin
         @(posedge clk); @(negedge clk);
         chk("tx1", {31'd0, tx1}, (j <= 10) ? fbit(d, j - 1) : 32'd1);
         chk("cnt1", {28'd0, dut1.COUNTER_t.count}, min10(j));
         chk("tx4", {31'd0, tx4}, (j <= 40) ? fbit(d, (j - 1) / 4) : 32'd1);
         chk("cnt4", {28'd0, dut4.COUNTER_t.count}, min10(j / 4));
         if (j == chg) din = d2;
         if (j == rst_at) begin
            rst = 1'b1;
            start = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("abort_tx1", {31'd0, tx1}, 32'd1);
            chk("abort_cnt1", {28'd0, dut1.COUNTER_t.count}, 32'd0);
            chk("abort_tx4", {31'd0, tx4}, 32'd1);
            chk("abort_cnt4", {28'd0, dut4.COUNTER_t.count}, 32'd0);
            rst = 1'b0;
            return;
         end
      end
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("release_tx1", {31'd0, tx1}, 32'd1);
      chk("release_cnt1", {28'd0, dut1.COUNTER_t.count}, 32'd0);
      chk("release_tx4", {31'd0, tx4}, 32'd1);
      chk("release_cnt4", {28'd0, dut4.COUNTER_t.count}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx1", {31'd0, tx1}, 32'd1);
      chk("rst_cnt1", {28'd0, dut1.COUNTER_t.count}, 32'd0);
      chk("rst_tx4", {31'd0, tx4}, 32'd1);
      chk("rst_cnt4", {28'd0, dut4.COUNTER_t.count}, 32'd0);
      rst = 1'b0;
      idle_check(3);

      run_frame(8'h58, 0, 8'h00, 0);
      idle_check(15);
      run_frame(8'hA5, 0, 8'h00, 0);
      idle_check(3);
      run_frame(8'hFF, 3, 8'h00, 0);
      idle_check(2);
      run_frame(8'h00, 0, 8'h00, 6);
      idle_check(2);
      run_frame(8'h01, 0, 8'h00, 0);
      idle_check(2);

      for (int k = 0; k < 6; k++) begin
         logic [7:0] rd, rd2;
         int         rc;
         rd  = 8'($urandom);
         rd2 = 8'($urandom);
         rc  = int'($urandom_range(0, 40));
         run_frame(rd, rc, rd2, 0);
         idle_check(int'($urandom_range(1, 10)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
